// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM SDRAM master among NUM_REQUESTERS cores.
// Tracks the owner of every outstanding read and steers readdatavalid back to it.
module sdram_arbiter #(
  parameter int unsigned NUM_REQUESTERS = 4,
  parameter int unsigned WORD_WIDTH     = 32,
  parameter int unsigned ADDRESS_WIDTH  = 24,
  parameter int unsigned MAX_PENDING    = 8
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic [NUM_REQUESTERS*ADDRESS_WIDTH-1:0] req_address,
  input  logic [NUM_REQUESTERS-1:0]               req_read,
  input  logic [NUM_REQUESTERS-1:0]               req_write,
  input  logic [NUM_REQUESTERS*WORD_WIDTH-1:0]    req_writedata,
  output logic [NUM_REQUESTERS-1:0]               req_waitrequest,
  output logic [WORD_WIDTH-1:0]                   req_readdata,
  output logic [NUM_REQUESTERS-1:0]               req_readdatavalid,
  output logic [ADDRESS_WIDTH-1:0]                sdram_address,
  output logic                                    sdram_read,
  output logic                                    sdram_write,
  output logic [WORD_WIDTH-1:0]                   sdram_writedata,
  input  logic                                    sdram_waitrequest,
  input  logic [WORD_WIDTH-1:0]                   sdram_readdata,
  input  logic                                    sdram_readdatavalid,
  output logic [$clog2(MAX_PENDING):0]            pending_count,
  output logic                                    protocol_error
);

  localparam int unsigned IDW = $clog2(NUM_REQUESTERS);
  localparam int unsigned PW  = $clog2(MAX_PENDING);
  localparam int unsigned CW  = PW + 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                   state_q, state_d;
  logic [IDW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]           grant_q, grant_d;
  logic [ADDRESS_WIDTH-1:0] sdram_address_q, sdram_address_d;
  logic                     sdram_read_q, sdram_read_d;
  logic                     sdram_write_q, sdram_write_d;
  logic [WORD_WIDTH-1:0]    sdram_writedata_q, sdram_writedata_d;
  logic [IDW-1:0]           fifo_q [MAX_PENDING];
  logic [IDW-1:0]           fifo_d [MAX_PENDING];
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     protocol_error_q, protocol_error_d;

  logic                      fifo_full;
  logic [NUM_REQUESTERS-1:0] eligible;
  logic                      pick_valid;
  logic [IDW-1:0]            pick_id;
  logic [IDW-1:0]            cand;
  logic [ADDRESS_WIDTH-1:0]  sel_address;
  logic [WORD_WIDTH-1:0]     sel_writedata;
  logic                      push;
  logic                      pop;

  assign fifo_full = (count_q == CW'(MAX_PENDING));

  // A requester asserting read (with or without write) is treated as a read,
  // so it waits for a free FIFO slot even if write is also asserted.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      eligible[i] = req_read[i] ? !fifo_full : req_write[i];
    end
  end

  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int unsigned k = 0; k < NUM_REQUESTERS; k++) begin
      cand = IDW'((32'(rr_ptr_q) + k) % NUM_REQUESTERS);
      if (!pick_valid && eligible[cand]) begin
        pick_valid = 1'b1;
        pick_id    = cand;
      end
    end
  end

  always_comb begin
    sel_address   = '0;
    sel_writedata = '0;
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      if (pick_id == IDW'(i)) begin
        sel_address   = req_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        sel_writedata = req_writedata[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  always_comb begin
    state_d           = state_q;
    rr_ptr_d          = rr_ptr_q;
    grant_d           = grant_q;
    sdram_address_d   = sdram_address_q;
    sdram_read_d      = sdram_read_q;
    sdram_write_d     = sdram_write_q;
    sdram_writedata_d = sdram_writedata_q;
    req_waitrequest   = '1;
    push              = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d           = ISSUE;
          grant_d           = pick_id;
          sdram_read_d      = req_read[pick_id];
          sdram_write_d     = !req_read[pick_id];
          sdram_address_d   = sel_address;
          sdram_writedata_d = sel_writedata;
        end
      end
      ISSUE: begin
        if (!sdram_waitrequest) begin
          req_waitrequest[grant_q] = 1'b0;
          push                     = sdram_read_q;
          sdram_read_d             = 1'b0;
          sdram_write_d            = 1'b0;
          rr_ptr_d = (grant_q == IDW'(NUM_REQUESTERS - 1)) ? '0 : grant_q + IDW'(1);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Responses are returned in issue order, so the FIFO head names the owner.
  always_comb begin
    pop               = sdram_readdatavalid && (count_q != '0);
    protocol_error_d  = protocol_error_q | (sdram_readdatavalid && (count_q == '0));
    req_readdata      = sdram_readdata;
    req_readdatavalid = '0;
    if (pop) req_readdatavalid[fifo_q[rd_ptr_q]] = 1'b1;
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = grant_q;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q           <= IDLE;
      rr_ptr_q          <= '0;
      grant_q           <= '0;
      sdram_address_q   <= '0;
      sdram_read_q      <= 1'b0;
      sdram_write_q     <= 1'b0;
      sdram_writedata_q <= '0;
      fifo_q            <= '{default: '0};
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      count_q           <= '0;
      protocol_error_q  <= 1'b0;
    end else begin
      state_q           <= state_d;
      rr_ptr_q          <= rr_ptr_d;
      grant_q           <= grant_d;
      sdram_address_q   <= sdram_address_d;
      sdram_read_q      <= sdram_read_d;
      sdram_write_q     <= sdram_write_d;
      sdram_writedata_q <= sdram_writedata_d;
      fifo_q            <= fifo_d;
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      count_q           <= count_d;
      protocol_error_q  <= protocol_error_d;
    end
  end

  assign sdram_address   = sdram_address_q;
  assign sdram_read      = sdram_read_q;
  assign sdram_write     = sdram_write_q;
  assign sdram_writedata = sdram_writedata_q;
  assign pending_count   = count_q;
  assign protocol_error  = protocol_error_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: queued requesters, a bench-driven SDRAM slave,
// and a scoreboard of expected commands/responses checked every cycle.
module tb_sdram_arbiter;
  localparam int NR = 4;
  localparam int AW = 24;
  localparam int WW = 32;
  localparam int MP = 8;

  logic               clock = 1'b0;
  logic               reset;
  logic [NR*AW-1:0]   req_address;
  logic [NR-1:0]      req_read, req_write;
  logic [NR*WW-1:0]   req_writedata;
  logic [NR-1:0]      req_waitrequest;
  logic [WW-1:0]      req_readdata;
  logic [NR-1:0]      req_readdatavalid;
  logic [AW-1:0]      sdram_address;
  logic               sdram_read, sdram_write;
  logic [WW-1:0]      sdram_writedata;
  logic               sdram_waitrequest;
  logic [WW-1:0]      sdram_readdata;
  logic               sdram_readdatavalid;
  logic [3:0]         pending_count;
  logic               protocol_error;

  always #5 clock = ~clock;

  sdram_arbiter #(.NUM_REQUESTERS(NR), .WORD_WIDTH(WW), .ADDRESS_WIDTH(AW), .MAX_PENDING(MP)) dut (
    .clock(clock), .reset(reset),
    .req_address(req_address), .req_read(req_read), .req_write(req_write),
    .req_writedata(req_writedata), .req_waitrequest(req_waitrequest),
    .req_readdata(req_readdata), .req_readdatavalid(req_readdatavalid),
    .sdram_address(sdram_address), .sdram_read(sdram_read), .sdram_write(sdram_write),
    .sdram_writedata(sdram_writedata), .sdram_waitrequest(sdram_waitrequest),
    .sdram_readdata(sdram_readdata), .sdram_readdatavalid(sdram_readdatavalid),
    .pending_count(pending_count), .protocol_error(protocol_error)
  );

  typedef struct {
    int unsigned id;
    logic        rd;
    logic        wr;
    logic [AW-1:0] addr;
    logic [WW-1:0] wdata;
    logic [WW-1:0] rdata;
  } txn_t;

  typedef struct {
    int unsigned   id;
    logic [WW-1:0] data;
    int unsigned   due;
  } rsp_t;

  txn_t rq [NR][$];
  txn_t cur_t [NR];
  bit   active [NR];
  bit   done_f [NR];
  txn_t cmd_q [$];
  rsp_t rsp_q [$];
  rsp_t cur_r;
  bit   cur_valid, cur_stray, stray_req, rsp_en;
  int unsigned cyc, lat;
  int   compared, mismatched;
  int   exp_pend;
  bit   exp_perr;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic txn_t mk(int unsigned id, logic rd, logic wr, logic [AW-1:0] a,
                              logic [WW-1:0] wd, logic [WW-1:0] rdat);
    txn_t t;
    t.id = id; t.rd = rd; t.wr = wr; t.addr = a; t.wdata = wd; t.rdata = rdat;
    return t;
  endfunction

  task automatic refill();
    for (int i = 0; i < NR; i++) begin
      if (!active[i] && rq[i].size() > 0) begin
        cur_t[i]  = rq[i].pop_front();
        active[i] = 1'b1;
        req_read[i]  = cur_t[i].rd;
        req_write[i] = cur_t[i].wr;
        req_address[i*AW +: AW]   = cur_t[i].addr;
        req_writedata[i*WW +: WW] = cur_t[i].wdata;
      end
    end
  endtask

  // Read+write together is serviced as a read.
  task automatic expect_cmd(txn_t t);
    txn_t e = t;
    e.wr = t.wr & ~t.rd;
    cmd_q.push_back(e);
  endtask

  task automatic post(txn_t t, bit exp);
    rq[t.id].push_back(t);
    if (exp) expect_cmd(t);
    refill();
  endtask

  task automatic observe();
    txn_t h;
    bit has_h, acc;
    logic [NR-1:0] exp_wr, exp_rdv;
    rsp_t r;
    has_h = cmd_q.size() > 0;
    if (has_h) h = cmd_q[0];
    acc = (sdram_read === 1'b1 || sdram_write === 1'b1) && !sdram_waitrequest;
    if (sdram_read === 1'b1 || sdram_write === 1'b1) begin
      if (!has_h) chk("cmd_unexpected", {sdram_read, sdram_write}, 2'b00);
      else begin
        chk("cmd_read", sdram_read, h.rd);
        chk("cmd_write", sdram_write, h.wr);
        chk("cmd_addr", sdram_address, h.addr);
        if (h.wr) chk("cmd_wdata", sdram_writedata, h.wdata);
      end
    end
    exp_wr = '1;
    if (acc && has_h) exp_wr[h.id] = 1'b0;
    chk("waitrequest", req_waitrequest, exp_wr);
    exp_rdv = '0;
    if (cur_valid && !cur_stray) begin
      exp_rdv[cur_r.id] = 1'b1;
      chk("readdata", req_readdata, cur_r.data);
    end
    chk("readdatavalid", req_readdatavalid, exp_rdv);
    chk("pending_count", pending_count, exp_pend);
    chk("protocol_error", protocol_error, exp_perr);
    for (int i = 0; i < NR; i++)
      if (active[i] && req_waitrequest[i] === 1'b0) done_f[i] = 1'b1;
    if (acc && has_h) begin
      h = cmd_q.pop_front();
      if (h.rd) begin
        r.id = h.id; r.data = h.rdata; r.due = cyc + lat;
        rsp_q.push_back(r);
        exp_pend++;
      end
    end
    if (cur_valid && !cur_stray) exp_pend--;
    if (cur_stray) exp_perr = 1'b1;
  endtask

  task automatic cycle();
    @(negedge clock);
    if (reset === 1'b0) observe();
    @(posedge clock);
    #1;
    cyc++;
    for (int i = 0; i < NR; i++) begin
      if (done_f[i]) begin
        active[i] = 1'b0; done_f[i] = 1'b0;
        req_read[i] = 1'b0; req_write[i] = 1'b0;
      end
    end
    refill();
    cur_valid = 1'b0;
    cur_stray = 1'b0;
    sdram_readdatavalid = 1'b0;
    if (stray_req) begin
      stray_req = 1'b0; cur_valid = 1'b1; cur_stray = 1'b1;
      sdram_readdatavalid = 1'b1; sdram_readdata = 32'hBAD0BAD0;
    end else if (rsp_en && rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      cur_r = rsp_q.pop_front();
      cur_valid = 1'b1;
      sdram_readdatavalid = 1'b1; sdram_readdata = cur_r.data;
    end
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  function automatic bit busy();
    bit b = cur_valid || cmd_q.size() > 0 || rsp_q.size() > 0;
    for (int i = 0; i < NR; i++) if (active[i] || rq[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic drain(string tag, int max);
    int n = 0;
    while (busy() && n < max) begin
      cycle();
      n++;
    end
    chk({"drain_", tag}, busy(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_read = '0; req_write = '0;
    sdram_readdatavalid = 1'b0; sdram_waitrequest = 1'b0;
    for (int i = 0; i < NR; i++) begin
      rq[i].delete(); active[i] = 1'b0; done_f[i] = 1'b0;
    end
    cmd_q.delete(); rsp_q.delete();
    cur_valid = 1'b0; cur_stray = 1'b0; stray_req = 1'b0;
    exp_pend = 0; exp_perr = 1'b0;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    compared = 0; mismatched = 0; cyc = 0; lat = 3; rsp_en = 1'b1;
    reset = 1'b1;
    req_address = '0; req_writedata = '0; req_read = '0; req_write = '0;
    sdram_waitrequest = 1'b0; sdram_readdata = '0; sdram_readdatavalid = 1'b0;

    // 1) reset values
    do_reset();
    chk("rst_sdram_read", sdram_read, 1'b0);
    chk("rst_sdram_write", sdram_write, 1'b0);
    chk("rst_sdram_address", sdram_address, '0);
    chk("rst_sdram_writedata", sdram_writedata, '0);
    chk("rst_req_waitrequest", req_waitrequest, 4'hF);
    chk("rst_req_readdatavalid", req_readdatavalid, 4'h0);
    chk("rst_pending_count", pending_count, 0);
    chk("rst_protocol_error", protocol_error, 1'b0);

    // 2) single read from requester 1, response 3 cycles after accept
    lat = 3;
    post(mk(1, 1'b1, 1'b0, 24'h000100, 32'h0, 32'hDEADBEEF), 1'b1);
    cycle();
    chk("t2_read_t1", sdram_read, 1'b1);
    chk("t2_addr_t1", sdram_address, 24'h000100);
    drain("t2", 50);

    // 3) all four read (r2 with read+write), r0 re-requests: grants 0,1,2,3,0
    do_reset();
    lat = 2;
    post(mk(0, 1'b1, 1'b0, 24'h000200, 32'h0, 32'h11110000), 1'b1);
    post(mk(1, 1'b1, 1'b0, 24'h000204, 32'h0, 32'h22221111), 1'b1);
    post(mk(2, 1'b1, 1'b1, 24'h000208, 32'hCAFE0002, 32'h33332222), 1'b1);
    post(mk(3, 1'b1, 1'b0, 24'h00020C, 32'h0, 32'h44443333), 1'b1);
    post(mk(0, 1'b1, 1'b0, 24'h000210, 32'h0, 32'h55554444), 1'b1);
    drain("t3", 100);

    // 4) write from r2 held off 5 cycles by the slave
    sdram_waitrequest = 1'b1;
    post(mk(2, 1'b0, 1'b1, 24'h000300, 32'hA5A55A5A, 32'h0), 1'b1);
    run(1);
    run(5);
    chk("t4_write_held", sdram_write, 1'b1);
    chk("t4_wdata_held", sdram_writedata, 32'hA5A55A5A);
    chk("t4_wait2_high", req_waitrequest[2], 1'b1);
    sdram_waitrequest = 1'b0;
    drain("t4", 20);

    // 5) fill the read FIFO, then a read stalls while a write still goes through
    rsp_en = 1'b0;
    lat = 1;
    for (int k = 0; k < 4; k++) begin
      post(mk(0, 1'b1, 1'b0, 24'h000400 + 24'(k*8), 32'h0, 32'h0A000000 + 32'(k)), 1'b1);
      post(mk(1, 1'b1, 1'b0, 24'h000404 + 24'(k*8), 32'h0, 32'h0B000000 + 32'(k)), 1'b1);
    end
    run(30);
    chk("t5_pending_full", pending_count, MP);
    post(mk(2, 1'b1, 1'b0, 24'h000480, 32'h0, 32'h0C0C0C0C), 1'b0);
    post(mk(3, 1'b0, 1'b1, 24'h0004C0, 32'h13579BDF, 32'h0), 1'b1);
    run(8);
    chk("t5_write_granted", cmd_q.size(), 0);
    chk("t5_read_stalled", req_waitrequest[2], 1'b1);
    chk("t5_pending_still_full", pending_count, MP);
    expect_cmd(mk(2, 1'b1, 1'b0, 24'h000480, 32'h0, 32'h0C0C0C0C));
    rsp_en = 1'b1;
    drain("t5", 100);

    // 6) stray response with nothing outstanding
    stray_req = 1'b1;
    run(4);
    chk("t6_perr_sticky", protocol_error, 1'b1);
    do_reset();
    chk("t6_perr_cleared", protocol_error, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
